// File: rtl/zuma_stream_config_loader.sv
// zuma_stream_config_loader
// Streams bitstream words from a valid/ready source into the ZUMA overlay
// config port, then pulses ffrst to reset the overlay flip-flops and reports
// done. A new start from RUN reloads the overlay at run time.
//
// Build option: define ZUMA_CFG_BITREV_EN to bit-reverse each word on its way
// to config_data, for stored bitstreams kept in the opposite bit order.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LOAD   | accepting words, one config strobe per accepted word
// VRESET | last word written, ffrst held for RESET_CYCLES cycles
// RUN    | overlay configured and released; start reloads
module zuma_stream_config_loader #(
  parameter int LUT_SIZE     = 6,
  parameter int NUM_STAGES   = 4,
  parameter int CONFIG_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int RESET_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [CONFIG_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [CONFIG_WIDTH-1:0] config_data,
  output logic [ADDR_WIDTH-1:0]   config_addr,
  output logic                    config_en,
  output logic                    ffrst,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   progress
);

  localparam int N = (2 ** LUT_SIZE) * NUM_STAGES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
  localparam int TW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VRESET = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   counter;
  logic [TW-1:0]           timer;
  logic                    beat;
  logic                    start_ok;
  logic [CONFIG_WIDTH-1:0] word_in;

  assign beat     = s_valid & s_ready;
  assign progress = counter;

`ifdef ZUMA_CFG_BITREV_EN
  // Mirror the incoming word so bit 0 of the stream lands on the overlay MSB.
  always_comb begin
    word_in = '0;
    for (int i = 0; i < CONFIG_WIDTH; i++) begin
      word_in[CONFIG_WIDTH-1-i] = s_data[i];
    end
  end
`else
  assign word_in = s_data;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs; start is only honoured when not loading.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    ffrst     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    start_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid && (counter == LAST_ADDR)) begin
          state_nxt = VRESET;
        end
      end
      VRESET: begin
        ffrst = 1'b1;
        busy  = 1'b1;
        if (timer == '0) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        done = 1'b1;
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flip-flop reset timer: preloaded outside VRESET, counts down inside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= TIMER_LOAD;
    end else if (state != VRESET) begin
      timer <= TIMER_LOAD;
    end else if (timer != '0) begin
      timer <= timer - TW'(1);
    end
  end

  // Config port registers and word counter; addr/data hold between beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      config_data <= '0;
      config_addr <= '0;
      config_en   <= 1'b0;
      counter     <= '0;
    end else begin
      config_en <= beat;
      if (beat) begin
        config_data <= word_in;
        config_addr <= counter;
        counter     <= counter + ADDR_WIDTH'(1);
      end
      if (start_ok) begin
        counter <= '0;
      end
    end
  end

endmodule
